// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Package  : led_pkg
// Brief    : Mode encodings, initial patterns and shared widths for the LED
//            pattern sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int SPEED_W = 2;

    localparam logic [1:0] MODE_BLINK  = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BINARY = 2'd3;

    localparam logic [3:0] PAT_INIT_BLINK  = 4'b0000;
    localparam logic [3:0] PAT_INIT_CHASE  = 4'b0001;
    localparam logic [3:0] PAT_INIT_BOUNCE = 4'b0001;
    localparam logic [3:0] PAT_INIT_BINARY = 4'b0000;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [3:0] init_pat(input logic [1:0] mode);
        logic [3:0] pat;
        case (mode)
            MODE_BLINK:  pat = PAT_INIT_BLINK;
            MODE_CHASE:  pat = PAT_INIT_CHASE;
            MODE_BOUNCE: pat = PAT_INIT_BOUNCE;
            default:     pat = PAT_INIT_BINARY;
        endcase
        return pat;
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : led_btn_debounce
// Brief    : Two-flop synchronizer, stability counter and single-cycle press
//            pulse on the accepted rising edge of a raw push-button.
// Revision : 1.0 - initial release
// ============================================================================
module led_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic             r_sync_a;
    logic             r_sync_b;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_a <= 1'b0;
            r_sync_b <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync_a <= i_btn;
            r_sync_b <= r_sync_a;
            r_press  <= 1'b0;
            if (r_sync_b != r_stable) begin
                if (r_cnt == C_CNT_MAX) begin
                    r_stable <= r_sync_b;
                    r_cnt    <= '0;
                    // Only an accepted release-to-press transition pulses.
                    r_press  <= r_sync_b;
                end else begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule : led_btn_debounce
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sequencer
// Brief    : Four-LED pattern generator (blink, chase, bounce, binary) with
//            button-selected mode and step speed.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV        = 10000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_mode,
    input  logic       btn_speed,
    output logic       led_1,
    output logic       led_2,
    output logic       led_3,
    output logic       led_4,
    output logic [1:0] mode_out
);

    localparam int                 PRE_W       = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]   C_PRE_ONE   = PRE_W'(1);
    localparam logic [SPEED_W-1:0] C_SPEED_ONE = SPEED_W'(1);

    logic               w_press_mode;
    logic               w_press_speed;
    logic               w_any_press;
    logic [PRE_W-1:0]   w_last;
    logic               w_tick;
    logic [1:0]         w_mode_inc;
    logic [3:0]         w_next_pat;
    logic               w_next_dir;

    logic [PRE_W-1:0]   r_presc;
    logic [SPEED_W-1:0] r_speed;
    logic [1:0]         r_mode;
    logic [3:0]         r_pat;
    logic               r_dir;

    led_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbc_mode (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_btn   (btn_mode),
        .o_press (w_press_mode)
    );

    led_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbc_speed (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_btn   (btn_speed),
        .o_press (w_press_speed)
    );

    // Each speed step halves the step period.
    assign w_last      = PRE_W'((TICK_DIV >> r_speed) - 1);
    assign w_any_press = w_press_mode | w_press_speed;
    assign w_tick      = (r_presc == w_last) & ~w_any_press;
    assign w_mode_inc  = r_mode + 2'd1;

    always_comb begin
        w_next_pat = r_pat;
        w_next_dir = r_dir;
        case (r_mode)
            MODE_BLINK: w_next_pat = ~r_pat;
            MODE_CHASE: w_next_pat = {r_pat[2:0], r_pat[3]};
            MODE_BOUNCE: begin
                // Turn around at the ends so no end position is shown twice.
                if (r_dir == DIR_UP) begin
                    if (r_pat == 4'b1000) begin
                        w_next_dir = DIR_DOWN;
                        w_next_pat = 4'b0100;
                    end else begin
                        w_next_pat = r_pat << 1;
                    end
                end else begin
                    if (r_pat == 4'b0001) begin
                        w_next_dir = DIR_UP;
                        w_next_pat = 4'b0010;
                    end else begin
                        w_next_pat = r_pat >> 1;
                    end
                end
            end
            default: w_next_pat = r_pat + 4'd1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_presc <= '0;
            r_speed <= '0;
            r_mode  <= MODE_BLINK;
            r_pat   <= PAT_INIT_BLINK;
            r_dir   <= DIR_UP;
        end else if (w_any_press) begin
            r_presc <= '0;
            if (w_press_mode) begin
                r_mode <= w_mode_inc;
                r_pat  <= init_pat(w_mode_inc);
                r_dir  <= DIR_UP;
            end
            if (w_press_speed) begin
                r_speed <= r_speed + C_SPEED_ONE;
            end
        end else if (w_tick) begin
            r_presc <= '0;
            r_pat   <= w_next_pat;
            r_dir   <= w_next_dir;
        end else begin
            r_presc <= r_presc + C_PRE_ONE;
        end
    end

    assign led_1    = r_pat[0];
    assign led_2    = r_pat[1];
    assign led_3    = r_pat[2];
    assign led_4    = r_pat[3];
    assign mode_out = r_mode;

endmodule : led_pattern_sequencer
`default_nettype wire

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Drives the four board LEDs (led_1..led_4) with one of four selectable patterns: blink, chase, bounce, binary count.
- Two push-buttons step the pattern mode and the step speed.
- Replaces the fixed free-running blinker as the top-level LED controller.
- Contains the tick prescaler, button conditioning, and the pattern state machine.

Parameters:
- TICK_DIV, 10000000, base clocks per pattern step at speed 0. Must be >= 8.
- DEBOUNCE_CYCLES, 1000000, clocks a synchronized button level must stay stable before it is accepted. Must be >= 2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- btn_mode  input  1  raw asynchronous button, active-high; a press advances the mode
- btn_speed  input  1  raw asynchronous button, active-high; a press advances the speed
- led_1  output  1  pattern bit 0
- led_2  output  1  pattern bit 1
- led_3  output  1  pattern bit 2
- led_4  output  1  pattern bit 3
- mode_out  output  2  current mode, for debug/status

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in; it is sampled only on the rising edge of clk_in.
- Reset values while rst_in=1, taking effect at the next clock edge:
  - pat=0000, all LEDs 0, mode=0 (BLINK), speed=0, dir=up, prescaler=0.
  - Synchronizers and debounce state are cleared; no press pulse is generated.
  - Asserting reset mid-operation aborts everything; there is no carry-over.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter counts while synced != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes synced.
  - Press pulse: one cycle, on the 0->1 transition of stable only. A held button gives exactly one pulse.
- Speed and period:
  - speed is 2 bits; period = TICK_DIV >> speed, i.e. TICK_DIV, /2, /4, /8.
  - Prescaler width is clog2(TICK_DIV). It counts 0..period-1.
  - tick is asserted in the cycle the prescaler equals period-1; the prescaler then wraps to 0.
- Mode press: mode <= mode+1 (mod 4); prescaler <= 0; pat and dir reload to the new mode's initial value.
- Speed press: speed <= speed+1 (mod 4); prescaler <= 0; pat unchanged.
- Any press cycle suppresses the tick in that cycle.
- Simultaneous mode and speed presses: both take effect in the same cycle.
- Mode initial values: BLINK 0000; CHASE 0001; BOUNCE 0001 with dir=up; BINARY 0000.
- Update on tick, by mode:
  - BLINK: pat <= ~pat.
  - CHASE: rotate left, 0001->0010->0100->1000->0001.
  - BOUNCE: shift in dir.
    - At 1000, dir becomes down and the next value is 0100.
    - At 0001 with dir down, dir becomes up and the next value is 0010.
    - Full sequence: 0001,0010,0100,1000,0100,0010,0001,0010...
  - BINARY: pat <= pat+1, wrapping 1111->0000.
- Outputs: led_n = pat[n-1] and mode_out = mode. Both are registered.
- Latency:
  - LED change appears 1 clock after the tick cycle.
  - Button edge to press pulse is 2 sync clocks + DEBOUNCE_CYCLES.

Decomposition:
- Shared package led_pkg:
  - Mode encodings: MODE_BLINK=0, MODE_CHASE=1, MODE_BOUNCE=2, MODE_BINARY=3.
  - Initial pattern constants.
  - Speed width constant.
- One sub-module: led_btn_debounce (synchronizer, debounce counter, rising-edge pulse), parameterized by DEBOUNCE_CYCLES and instantiated twice.
- Prescaler and pattern FSM stay in the top module.

Test Plan (TICK_DIV=8, DEBOUNCE_CYCLES=4):
- Reset/BLINK: hold rst_in 3 cycles, release, no buttons -> LEDs 0000, mode_out=0; LEDs become 1111 after 8 clocks and 0000 after 16; toggling continues every 8 clocks.
- Debounce and mode step:
  - btn_mode glitch high for 2 cycles -> no mode change.
  - btn_mode held high for 20 cycles -> exactly one change, mode_out=1 (CHASE) and LEDs 0001.
  - After that, LEDs step 0010,0100,1000,0001 every 8 clocks.
- Speed: in CHASE, press btn_speed three times -> speed=3, period=1; LEDs rotate every clock. A fourth press -> period back to 8.
- BOUNCE: select mode 2 -> LEDs 0001,0010,0100,1000,0100,0010,0001,0010 on successive ticks; no step repeats an end position.
- BINARY wrap and simultaneous press:
  - Mode 3 at speed 3 -> LEDs count 0000..1111 then 0000.
  - Pressing both buttons in the same cycle -> mode 0, speed 0, prescaler 0, LEDs 0000.
- Reset mid-operation: assert rst_in during a BOUNCE down-sweep at speed 2 -> next cycle LEDs 0000, mode_out=0, speed=0; the next tick comes 8 clocks after release.
